// File: rtl/spi_peripheral.sv
// Write-only SPI register peripheral: frames 16-bit MSB-first words from
// pre-synchronized nCS/COPI/SCLK and commits write frames to five control registers.
//
// state   | meaning
// IDLE    | waiting for nCS fall; SCLK ignored
// RECEIVE | shifting COPI on SCLK rise, up to 16 bits
// OVERRUN | more than 16 SCLK rises seen; frame will be rejected
module spi_peripheral #(
  parameter logic [6:0] MAX_ADDR = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sync_in,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, RECEIVE, OVERRUN} state_t;

  state_t      state;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic        sclk_prev;
  logic        ncs_prev;

  logic sclk_rise, ncs_fall, ncs_rise, commit_ok;

  assign sclk_rise = !sclk_prev && sync_in[0];
  assign ncs_fall  = ncs_prev && !sync_in[2];
  assign ncs_rise  = !ncs_prev && sync_in[2];
  assign commit_ok = (bit_cnt == 5'd16) && shift_reg[15] && (shift_reg[14:8] <= MAX_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      sclk_prev       <= 1'b0;
      ncs_prev        <= 1'b1;
      frame_done      <= 1'b0;
      frame_err       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      sclk_prev  <= sync_in[0];
      ncs_prev   <= sync_in[2];
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            state     <= RECEIVE;
          end
        end
        RECEIVE: begin
          // nCS rise wins over a coincident SCLK rise; the frame is judged on the prior count
          if (ncs_rise) begin
            if (commit_ok) begin
              case (shift_reg[14:8])
                7'h00:   en_reg_out_7_0  <= shift_reg[7:0];
                7'h01:   en_reg_out_15_8 <= shift_reg[7:0];
                7'h02:   en_reg_pwm_7_0  <= shift_reg[7:0];
                7'h03:   en_reg_pwm_15_8 <= shift_reg[7:0];
                7'h04:   pwm_duty_cycle  <= shift_reg[7:0];
                default: ;
              endcase
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end else if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
          end else if (sclk_rise && !sync_in[2]) begin
            if (bit_cnt == 5'd16) begin
              state <= OVERRUN;
            end else begin
              shift_reg <= {shift_reg[14:0], sync_in[1]};
              bit_cnt   <= bit_cnt + 5'd1;
            end
          end
        end
        OVERRUN: begin
          if (ncs_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            state     <= RECEIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: drives SPI frames at the synchronized
// inputs and compares registers and frame pulses against hand-computed values.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ncs, copi, sclk;
  logic [2:0] sync_in;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       frame_done, frame_err;

  logic [7:0] exp_reg [5];
  int n_chk  = 0;
  int n_pass = 0;

  assign sync_in = {ncs, copi, sclk};

  always #50 clk = ~clk;

  spi_peripheral #(.MAX_ADDR(7'h04)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sync_in         (sync_in),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .frame_done      (frame_done),
    .frame_err       (frame_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    check({tag, " reg00"}, {8'h00, en_reg_out_7_0},  {8'h00, exp_reg[0]});
    check({tag, " reg01"}, {8'h00, en_reg_out_15_8}, {8'h00, exp_reg[1]});
    check({tag, " reg02"}, {8'h00, en_reg_pwm_7_0},  {8'h00, exp_reg[2]});
    check({tag, " reg03"}, {8'h00, en_reg_pwm_15_8}, {8'h00, exp_reg[3]});
    check({tag, " reg04"}, {8'h00, pwm_duty_cycle},  {8'h00, exp_reg[4]});
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      sclk = 1'b0;
      tick(2);
      sclk = 1'b1;
      tick(2);
    end
    sclk = 1'b0;
    tick(2);
  endtask

  // Raise nCS and require exactly a one-cycle pulse of the expected kind.
  task automatic end_frame(input string tag, input logic exp_done, input logic exp_err);
    ncs = 1'b1;
    tick(1);
    check({tag, " done"}, {15'd0, frame_done}, {15'd0, exp_done});
    check({tag, " err"},  {15'd0, frame_err},  {15'd0, exp_err});
    tick(1);
    check({tag, " done clr"}, {15'd0, frame_done}, 16'd0);
    check({tag, " err clr"},  {15'd0, frame_err},  16'd0);
    tick(2);
  endtask

  task automatic frame(input string tag, input logic [31:0] bits, input int n,
                       input logic exp_done, input logic exp_err);
    ncs = 1'b0;
    tick(2);
    send_bits(bits, n);
    end_frame(tag, exp_done, exp_err);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
    rst_n = 1'b0; ncs = 1'b1; copi = 1'b0; sclk = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst done", {15'd0, frame_done}, 16'd0);
    check("rst err",  {15'd0, frame_err},  16'd0);
    check_regs("rst");

    frame("w00", 32'h80F0, 16, 1'b1, 1'b0);
    exp_reg[0] = 8'hF0;
    check_regs("w00");

    frame("w04", 32'h8480, 16, 1'b1, 1'b0);
    frame("w03", 32'h83FF, 16, 1'b1, 1'b0);
    exp_reg[4] = 8'h80;
    exp_reg[3] = 8'hFF;
    check_regs("b2b");

    frame("read", 32'h0055, 16, 1'b0, 1'b1);
    frame("addr5", 32'h8555, 16, 1'b0, 1'b1);
    check_regs("invalid");

    frame("15bit", 32'h40D5, 15, 1'b0, 1'b1);
    frame("17bit", 32'h10354, 17, 1'b0, 1'b1);
    check_regs("bitcnt");
    frame("w01", 32'h81AA, 16, 1'b1, 1'b0);
    exp_reg[1] = 8'hAA;
    check_regs("w01");

    // Abort a frame with reset after 8 bits; nCS goes high while reset is held.
    ncs = 1'b0;
    tick(2);
    send_bits(32'h82, 8);
    rst_n = 1'b0;
    tick(1);
    ncs = 1'b1;
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("abort pulse", {14'd0, frame_done, frame_err}, 16'd0);
    end
    for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
    check_regs("abort");
    frame("w02", 32'h823C, 16, 1'b1, 1'b0);
    exp_reg[2] = 8'h3C;
    check_regs("w02");

    // 16th SCLK rise lands in the same cycle as the nCS rise.
    ncs = 1'b0;
    tick(2);
    send_bits(32'h8311 >> 1, 15);
    copi = 1'b1;
    sclk = 1'b1;
    end_frame("coinc", 1'b0, 1'b1);
    sclk = 1'b0;
    tick(2);
    check_regs("coinc");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
